// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one request/ack read per PC, buffers the
// returned {pc, instr} pairs in a small circular queue for decode, stalls
// the PC register while a fetch is outstanding or the queue is full, and
// discards queue contents plus any in-flight fetch on a redirect flush.
module ifetch_unit #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        fetch_block,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  // DROP: a flushed fetch is still waiting on memory; its data is thrown away.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_req;
  logic [31:0]           r_addr;
  logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]        r_count;
  logic [DEPTH-1:0][31:0] r_q_pc, r_q_instr;

  logic w_issue, w_push, w_pop, w_full;

  assign w_full = (r_count == (PTR_W+1)'(DEPTH));

  // Next-state decode; also flags when a fetch is issued or its data is kept.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_push      = !flush;
          w_state_nxt = S_IDLE;
        end else if (flush) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flush wins over a pop, so that cycle's id_ready is ignored.
  assign w_pop = (r_count != '0) & id_ready & !flush;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Request stays up through DROP: a memory transaction is never abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_req <= (w_state_nxt != S_IDLE);
      if (w_issue) r_addr <= pc_in;
    end
  end

  // Queue control: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; flush leaves contents alone, only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_pc    <= '0;
      r_q_instr <= '0;
    end else if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_addr;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign id_valid    = (r_count != '0);
  assign id_pc       = r_q_pc[r_rd_ptr];
  assign id_instr    = r_q_instr[r_rd_ptr];
  // Low during flush so the PC register takes the redirect target.
  assign fetch_block = !flush & ((r_state != S_IDLE) | w_full);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: reset checks, a streaming vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_ifetch_unit;
  localparam int DEPTH = 2;

  logic        clk, rst, flush, fetch_block, imem_req, imem_ack, id_valid, id_ready;
  logic [31:0] pc_in, imem_addr, imem_rdata, id_pc, id_instr;

  ifetch_unit #(.DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
    .fetch_block(fetch_block), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: one outstanding fetch (busy), whether its data is to be dropped,
  // its address, and a queue of delivered {pc, instr} pairs.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  bit          busy, discard;
  logic [31:0] m_addr;

  task automatic model_reset();
    busy = 0; discard = 0; m_addr = '0; q.delete();
  endtask

  task automatic model_check();
    chk("m_fetch_block", {31'b0, fetch_block}, {31'b0, !flush && (busy || q.size() == DEPTH)});
    chk("m_imem_req",    {31'b0, imem_req},    {31'b0, busy});
    chk("m_imem_addr",   imem_addr,            m_addr);
    chk("m_id_valid",    {31'b0, id_valid},    {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("m_id_pc",    id_pc,    q[0].pc);
      chk("m_id_instr", id_instr, q[0].instr);
    end
  endtask

  task automatic model_edge();
    int   sz = q.size();
    bit   pushv = 0;
    ent_t e;
    if (!busy) begin
      if (!flush && sz < DEPTH) begin busy = 1; m_addr = pc_in; end
    end else if (imem_ack) begin
      pushv = !flush && !discard;
      busy = 0; discard = 0;
    end else if (flush) begin
      discard = 1;
    end
    if (flush) q.delete();
    else begin
      if (id_ready && sz > 0) void'(q.pop_front());
      if (pushv) begin e.pc = m_addr; e.instr = imem_rdata; q.push_back(e); end
    end
  endtask

  // Called at a negedge: drive inputs, let them settle, compare with model.
  task automatic apply(input logic [31:0] pc, input logic fl, input logic ack,
                       input logic [31:0] rd, input logic rdy);
    pc_in = pc; flush = fl; imem_ack = ack; imem_rdata = rd; id_ready = rdy;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pc_in = '0; flush = 0; imem_ack = 0; imem_rdata = '0; id_ready = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc; logic fl, ack; logic [31:0] rd; logic rdy;
    logic fb, req; logic [31:0] addr; logic vld; logic [31:0] hpc, hins;
  } vec_t;
  vec_t tbl[7];

  initial begin
    // Streaming: zero-wait memory, decode always ready; PC holds while blocked.
    tbl[0] = '{32'h00400000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
    tbl[1] = '{32'h00400004, 1'b0, 1'b1, 32'h1111, 1'b1, 1'b1, 1'b1, 32'h00400000, 1'b0, 32'h0,        32'h0};
    tbl[2] = '{32'h00400004, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00400000, 32'h1111};
    tbl[3] = '{32'h00400008, 1'b0, 1'b1, 32'h2222, 1'b1, 1'b1, 1'b1, 32'h00400004, 1'b0, 32'h0,        32'h0};
    tbl[4] = '{32'h00400008, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00400004, 32'h2222};
    tbl[5] = '{32'h0040000c, 1'b0, 1'b1, 32'h3333, 1'b1, 1'b1, 1'b1, 32'h00400008, 1'b0, 32'h0,        32'h0};
    tbl[6] = '{32'h0040000c, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00400008, 32'h3333};

    // Reset with random inputs, no clock edge involved.
    rst = 1'b1;
    pc_in = $urandom; flush = 1'($urandom); imem_ack = 1'($urandom);
    imem_rdata = $urandom; id_ready = 1'($urandom);
    #1 rst = 1'b0;
    #1;
    chk("rst_imem_req",    {31'b0, imem_req},    32'd0);
    chk("rst_id_valid",    {31'b0, id_valid},    32'd0);
    chk("rst_fetch_block", {31'b0, fetch_block}, 32'd0);
    chk("rst_id_pc",       id_pc,                32'd0);
    chk("rst_id_instr",    id_instr,             32'd0);
    chk("rst_imem_addr",   imem_addr,            32'd0);
    model_reset();
    pc_in = '0; flush = 0; imem_ack = 0; imem_rdata = '0; id_ready = 0;
    @(negedge clk);
    rst = 1'b1;

    // Streaming table.
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].rd, tbl[i].rdy);
      chk($sformatf("tbl%0d_fb", i),  {31'b0, fetch_block}, {31'b0, tbl[i].fb});
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req},    {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_vld", i), {31'b0, id_valid},    {31'b0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i),    id_pc,    tbl[i].hpc);
        chk($sformatf("tbl%0d_instr", i), id_instr, tbl[i].hins);
      end
      tick();
    end

    // Backpressure: fill both entries, then drain in order.
    do_reset();
    apply(32'h00400000, 0, 0, 32'h0,    0); tick();
    apply(32'h00400004, 0, 1, 32'hAAAA, 0); tick();
    apply(32'h00400004, 0, 0, 32'h0,    0); tick();
    apply(32'h00400008, 0, 1, 32'hBBBB, 0); tick();
    apply(32'h00400008, 0, 0, 32'h0,    0);
    chk("bp_full_block", {31'b0, fetch_block}, 32'd1);
    chk("bp_full_req",   {31'b0, imem_req},    32'd0);
    chk("bp_head_pc",    id_pc,                32'h00400000);
    tick();
    apply(32'h00400008, 0, 0, 32'h0, 1);
    chk("bp_still_idle", {31'b0, imem_req}, 32'd0);
    chk("bp_drain0",     id_instr,          32'hAAAA);
    tick();
    apply(32'h00400008, 0, 0, 32'h0, 0);
    chk("bp_drain1_pc", id_pc,                32'h00400004);
    chk("bp_unblock",   {31'b0, fetch_block}, 32'd0);
    tick();
    apply(32'h0040000c, 0, 1, 32'hCCCC, 0);
    chk("bp_refetch_req",  {31'b0, imem_req}, 32'd1);
    chk("bp_refetch_addr", imem_addr,         32'h00400008);
    tick();

    // Flush while waiting on memory: late data discarded.
    do_reset();
    apply(32'h00400000, 0, 0, 32'h0, 1); tick();
    apply(32'h00400000, 1, 0, 32'h0, 1);
    chk("fw_block_low", {31'b0, fetch_block}, 32'd0);
    tick();
    apply(32'h00400100, 0, 0, 32'h0, 1);
    chk("fw_drop_req", {31'b0, imem_req}, 32'd1);
    tick();
    apply(32'h00400100, 0, 1, 32'hDEAD, 1); tick();
    apply(32'h00400100, 0, 0, 32'h0, 1);
    chk("fw_no_valid", {31'b0, id_valid}, 32'd0);
    tick();
    apply(32'h00400104, 0, 1, 32'hBEEF, 0);
    chk("fw_new_addr", imem_addr, 32'h00400100);
    tick();
    apply(32'h00400104, 0, 0, 32'h0, 0);
    chk("fw_new_instr", id_instr, 32'hBEEF);
    tick();

    // Flush together with ack and a pop while one entry is queued.
    do_reset();
    apply(32'h00400000, 0, 0, 32'h0,  0); tick();
    apply(32'h00400004, 0, 1, 32'h11, 0); tick();
    apply(32'h00400004, 0, 0, 32'h0,  0); tick();
    apply(32'h00400008, 1, 1, 32'h22, 1); tick();
    apply(32'h00400008, 0, 0, 32'h0,  0);
    chk("fa_valid", {31'b0, id_valid}, 32'd0);
    chk("fa_req",   {31'b0, imem_req}, 32'd0);
    tick();

    // Asynchronous reset between edges while a fetch is outstanding.
    do_reset();
    apply(32'h00400000, 0, 0, 32'h0,  0); tick();
    apply(32'h00400004, 0, 1, 32'h55, 0); tick();
    apply(32'h00400004, 0, 0, 32'h0,  0); tick();
    chk("ar_pre_req",   {31'b0, imem_req}, 32'd1);
    chk("ar_pre_valid", {31'b0, id_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},    32'd0);
    chk("ar_valid", {31'b0, id_valid},    32'd0);
    chk("ar_block", {31'b0, fetch_block}, 32'd0);
    model_reset();
    pc_in = 32'h00500000; flush = 0; imem_ack = 0; id_ready = 0;
    @(negedge clk);
    rst = 1'b1;
    apply(32'h00500000, 0, 0, 32'h0, 0); tick();
    apply(32'h00500004, 0, 0, 32'h0, 0);
    chk("ar_first_addr", imem_addr, 32'h00500000);
    tick();

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      apply($urandom, $urandom_range(0, 9) == 0, 1'($urandom),
            $urandom, $urandom_range(0, 9) < 6);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
